// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline.
// Writeback select, load type and register constants.
package mips_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;

    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LHU = 3'b010;
    localparam logic [2:0] LD_LB  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_align.sv
// Big-endian load extraction and sign/zero extension.
// Purely combinational; alignment faults are trapped upstream.
module load_align
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        load_type,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] data
);

    logic [15:0] half;
    logic [7:0]  lane;

    always_comb begin
        half = addr[1] ? word[15:0] : word[31:16];
        lane = word[31:24];
        unique case (addr)
            2'd0: lane = word[31:24];
            2'd1: lane = word[23:16];
            2'd2: lane = word[15:8];
            2'd3: lane = word[7:0];
        endcase
        data = word;
        case (load_type)
            LD_LH:   data = {{(DATA_W-16){half[15]}}, half};
            LD_LHU:  data = {{(DATA_W-16){1'b0}}, half};
            LD_LB:   data = {{(DATA_W-8){lane[7]}}, lane};
            LD_LBU:  data = {{(DATA_W-8){1'b0}}, lane};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, writeback select and retire counter.
// Register file writes on negedge, so registered outputs are stable.
module writeback_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              Rest,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic [4:0]        mem_d_addr,
    input  logic [1:0]        mem_wb_sel,
    input  logic [2:0]        mem_load_type,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_load_data,
    input  logic [DATA_W-1:0] mem_pc_plus4,
    output logic              write_sig,
    output logic [4:0]        d_addr,
    output logic [DATA_W-1:0] writeback_data,
    output logic              wb_valid,
    output logic [CNT_W-1:0]  retired_count
);

    logic              wb_reg_write;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] sel_data;

    load_align #(.DATA_W(DATA_W)) u_align (
        .load_type (mem_load_type),
        .addr      (mem_alu_result[1:0]),
        .word      (mem_load_data),
        .data      (load_val)
    );

    always_comb begin
        sel_data = mem_alu_result;
        case (mem_wb_sel)
            WB_SEL_LOAD: sel_data = load_val;
            WB_SEL_LINK: sel_data = mem_pc_plus4 + DATA_W'(4);
            default:     sel_data = mem_alu_result;
        endcase
    end

    always_ff @(posedge clock) begin
        if (Rest) begin
            wb_valid       <= 1'b0;
            wb_reg_write   <= 1'b0;
            d_addr         <= REG_ZERO;
            writeback_data <= '0;
        end else if (flush) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
        end else if (!stall) begin
            wb_valid       <= mem_valid;
            wb_reg_write   <= mem_reg_write;
            d_addr         <= mem_d_addr;
            writeback_data <= sel_data;
        end
    end

    // An instruction retires when it leaves WB, even if flushed out.
    always_ff @(posedge clock) begin
        if (Rest)
            retired_count <= '0;
        else if (wb_valid && !stall)
            retired_count <= retired_count + CNT_W'(1);
    end

    assign write_sig = wb_valid & wb_reg_write & (d_addr != REG_ZERO);

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage.
// Expected results queued at issue, checked as each instruction leaves WB.
module tb_writeback_stage;

    typedef struct {
        logic        ws;
        logic [4:0]  da;
        logic [31:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        Rest = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_reg_write = 1'b0;
    logic [4:0]  mem_d_addr = '0;
    logic [1:0]  mem_wb_sel = '0;
    logic [2:0]  mem_load_type = '0;
    logic [31:0] mem_alu_result = '0;
    logic [31:0] mem_load_data = '0;
    logic [31:0] mem_pc_plus4 = '0;
    logic        write_sig;
    logic [4:0]  d_addr;
    logic [31:0] writeback_data;
    logic        wb_valid;
    logic [3:0]  retired_count;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    writeback_stage #(.DATA_W(32), .CNT_W(4)) dut (
        .clock          (clock),
        .Rest           (Rest),
        .stall          (stall),
        .flush          (flush),
        .mem_valid      (mem_valid),
        .mem_reg_write  (mem_reg_write),
        .mem_d_addr     (mem_d_addr),
        .mem_wb_sel     (mem_wb_sel),
        .mem_load_type  (mem_load_type),
        .mem_alu_result (mem_alu_result),
        .mem_load_data  (mem_load_data),
        .mem_pc_plus4   (mem_pc_plus4),
        .write_sig      (write_sig),
        .d_addr         (d_addr),
        .writeback_data (writeback_data),
        .wb_valid       (wb_valid),
        .retired_count  (retired_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: the slot departs on the coming posedge.
    always @(negedge clock) begin
        if (wb_valid === 1'b1 && !stall && !Rest) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL retire: unexpected d=%0d data=%h",
                         d_addr, writeback_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (write_sig !== e.ws || d_addr !== e.da ||
                    writeback_data !== e.data) begin
                    miscompares++;
                    $display("FAIL retire: got ws=%b d=%0d data=%h want ws=%b d=%0d data=%h",
                             write_sig, d_addr, writeback_data,
                             e.ws, e.da, e.data);
                end
            end
        end
    end

    task automatic issue(input bit push, input logic v, input logic rw,
                         input logic [4:0] da, input logic [1:0] sel,
                         input logic [2:0] lt, input logic [31:0] alu,
                         input logic [31:0] ld, input logic [31:0] pc,
                         input logic ws, input logic [31:0] exp);
        exp_t e;
        mem_valid      = v;
        mem_reg_write  = rw;
        mem_d_addr     = da;
        mem_wb_sel     = sel;
        mem_load_type  = lt;
        mem_alu_result = alu;
        mem_load_data  = ld;
        mem_pc_plus4   = pc;
        if (push) begin
            e.ws = ws;
            e.da = da;
            e.data = exp;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic bubble();
        issue(0, 0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 0, 32'h0);
    endtask

    localparam logic [31:0] W = 32'h80FF_7F01;

    initial begin
        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            stall          = 1'($urandom);
            flush          = 1'($urandom);
            mem_valid      = 1'($urandom);
            mem_reg_write  = 1'($urandom);
            mem_d_addr     = 5'($urandom);
            mem_wb_sel     = 2'($urandom);
            mem_load_type  = 3'($urandom);
            mem_alu_result = $urandom;
            mem_load_data  = $urandom;
            mem_pc_plus4   = $urandom;
            @(posedge clock);
            #1;
        end
        chk("reset_outs", {23'd0, write_sig, d_addr, writeback_data, wb_valid},
            64'd0);
        chk("reset_cnt", 64'(retired_count), 64'd0);
        Rest = 1'b0;
        stall = 1'b0;
        flush = 1'b0;

        // ALU path
        issue(1, 1, 1, 5'd5, 2'b00, 3'd0, 32'h0000_1234, 32'h0, 32'h0,
              1, 32'h0000_1234);
        chk("alu_ws", 64'(write_sig), 64'd1);
        bubble();
        chk("alu_cnt", 64'(retired_count), 64'd1);

        // Loads
        issue(1, 1, 1, 5'd8,  2'b01, 3'b011, 32'h1000, W, 32'h0, 1, 32'hFFFF_FF80);
        issue(1, 1, 1, 5'd9,  2'b01, 3'b100, 32'h1000, W, 32'h0, 1, 32'h0000_0080);
        issue(1, 1, 1, 5'd10, 2'b01, 3'b011, 32'h1002, W, 32'h0, 1, 32'h0000_007F);
        issue(1, 1, 1, 5'd11, 2'b01, 3'b001, 32'h1000, W, 32'h0, 1, 32'hFFFF_80FF);
        issue(1, 1, 1, 5'd12, 2'b01, 3'b010, 32'h1002, W, 32'h0, 1, 32'h0000_7F01);
        issue(1, 1, 1, 5'd13, 2'b01, 3'b000, 32'h1003, W, 32'h0, 1, 32'h80FF_7F01);
        bubble();
        chk("load_cnt", 64'(retired_count), 64'd7);

        // Link, including r0 destination
        issue(1, 1, 1, 5'd31, 2'b10, 3'd0, 32'h0, 32'h0, 32'h0040_0010,
              1, 32'h0040_0014);
        issue(1, 1, 1, 5'd0, 2'b10, 3'd0, 32'h0, 32'h0, 32'h0040_0010,
              0, 32'h0040_0014);
        chk("link_r0_ws", 64'(write_sig), 64'd0);
        bubble();
        chk("link_cnt", 64'(retired_count), 64'd9);

        // Stall holds for three cycles
        issue(1, 1, 1, 5'd7, 2'b00, 3'd0, 32'hAAAA_0001, 32'h0, 32'h0,
              1, 32'hAAAA_0001);
        mem_d_addr = 5'd9;
        mem_alu_result = 32'hBBBB_0000;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            chk("stall_outs", {26'd0, write_sig, d_addr, writeback_data},
                {26'd0, 1'b1, 5'd7, 32'hAAAA_0001});
            chk("stall_cnt", 64'(retired_count), 64'd9);
        end
        stall = 1'b0;
        issue(1, 1, 1, 5'd9, 2'b00, 3'd0, 32'hBBBB_0000, 32'h0, 32'h0,
              1, 32'hBBBB_0000);
        chk("release_cnt", 64'(retired_count), 64'd10);
        chk("release_d", 64'(d_addr), 64'd9);
        bubble();
        chk("release_cnt2", 64'(retired_count), 64'd11);

        // Flush with stall gives a bubble and no retire
        issue(0, 1, 1, 5'd3, 2'b00, 3'd0, 32'h3333, 32'h0, 32'h0, 1, 32'h0);
        flush = 1'b1;
        stall = 1'b1;
        mem_d_addr = 5'd2;
        @(posedge clock);
        #1;
        chk("fs_valid", 64'(wb_valid), 64'd0);
        chk("fs_ws", 64'(write_sig), 64'd0);
        chk("fs_cnt", 64'(retired_count), 64'd11);
        flush = 1'b0;
        stall = 1'b0;

        // Flush alone still retires the departing instruction
        issue(1, 1, 1, 5'd4, 2'b00, 3'd0, 32'h0000_00EE, 32'h0, 32'h0,
              1, 32'h0000_00EE);
        flush = 1'b1;
        bubble();
        chk("flush_cnt", 64'(retired_count), 64'd12);
        chk("flush_valid", 64'(wb_valid), 64'd0);
        flush = 1'b0;

        // Reset together with flush
        issue(0, 1, 1, 5'd6, 2'b00, 3'd0, 32'h6666, 32'h0, 32'h0, 1, 32'h0);
        Rest = 1'b1;
        flush = 1'b1;
        bubble();
        chk("rst_flush_outs",
            {23'd0, write_sig, d_addr, writeback_data, wb_valid}, 64'd0);
        chk("rst_flush_cnt", 64'(retired_count), 64'd0);
        Rest = 1'b0;
        flush = 1'b0;

        // Counter wrap at 2^CNT_W
        for (int i = 0; i < 16; i++) begin
            issue(1, 1, 1, 5'(i + 1), 2'b00, 3'd0, 32'h100 + 32'(i),
                  32'h0, 32'h0, 1, 32'h100 + 32'(i));
            if (i == 15)
                chk("wrap_max", 64'(retired_count), 64'd15);
        end
        bubble();
        chk("wrap_zero", 64'(retired_count), 64'd0);
        bubble();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
